// File: rtl/tnoc_vc_output_mux.sv
// Per-VC to single-link output multiplexer: round-robin packet arbitration with
// wormhole locking and a registered one-flit output stage.
module tnoc_vc_output_mux #(
  parameter int CHANNELS   = 2,
  parameter int FLIT_WIDTH = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_clear,
  input  logic [CHANNELS-1:0]                  i_valid,
  output logic [CHANNELS-1:0]                  o_ready,
  input  logic [CHANNELS-1:0][FLIT_WIDTH-1:0]  i_flit,
  input  logic [CHANNELS-1:0]                  i_tail,
  input  logic [CHANNELS-1:0]                  i_vc_almost_full,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [FLIT_WIDTH-1:0]                o_flit,
  output logic                                 o_tail,
  output logic [CHANNELS-1:0]                  o_vc
);

  localparam int IW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t                  state_reg, state_next;
  logic [IW-1:0]           rr_ptr_reg, rr_ptr_next;
  logic [IW-1:0]           lock_vc_reg, lock_vc_next;

  logic                    o_valid_reg;
  logic [FLIT_WIDTH-1:0]   o_flit_reg;
  logic                    o_tail_reg;
  logic [CHANNELS-1:0]     o_vc_reg;

  logic                    flush;
  logic                    load_en;
  logic [CHANNELS-1:0]     request;
  logic [CHANNELS-1:0]     lock_onehot;
  logic [CHANNELS-1:0]     grant;
  logic [IW-1:0]           grant_idx;
  logic [CHANNELS-1:0]     ready_vec;
  logic [CHANNELS-1:0]     xfer_vec;
  logic                    transfer;
  logic [IW-1:0]           xfer_idx;
  logic                    xfer_tail;
  logic [FLIT_WIDTH-1:0]   xfer_flit;

  assign flush   = rst | i_clear;
  assign load_en = !o_valid_reg || i_ready;

  // Almost-full only gates new packet heads; a locked packet ignores it.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign request[gi]     = i_valid[gi] && !i_vc_almost_full[gi];
    assign lock_onehot[gi] = (lock_vc_reg == IW'(gi));
  end

  always_comb begin
    int  cand;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand = int'(rr_ptr_reg) + k;
      if (cand >= CHANNELS) cand = cand - CHANNELS;
      if (!found && request[cand]) begin
        found       = 1'b1;
        grant_idx   = IW'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

  // FSM output process: upstream accept vector.
  always_comb begin
    ready_vec = '0;
    if (!flush && load_en) begin
      if (state_reg == IDLE) ready_vec = grant;
      else                   ready_vec = lock_onehot;
    end
  end

  assign o_ready   = ready_vec;
  assign xfer_vec  = i_valid & ready_vec;
  assign transfer  = |xfer_vec;
  assign xfer_idx  = (state_reg == IDLE) ? grant_idx : lock_vc_reg;
  assign xfer_tail = i_tail[xfer_idx];
  assign xfer_flit = i_flit[xfer_idx];

  always_comb begin
    state_next   = state_reg;
    rr_ptr_next  = rr_ptr_reg;
    lock_vc_next = lock_vc_reg;
    case (state_reg)
      IDLE: begin
        if (transfer) begin
          rr_ptr_next = (grant_idx == IW'(CHANNELS - 1)) ? '0 : grant_idx + IW'(1);
          if (!xfer_tail) begin
            state_next   = BUSY;
            lock_vc_next = grant_idx;
          end
        end
      end
      BUSY: begin
        if (transfer && xfer_tail) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      state_reg   <= IDLE;
      rr_ptr_reg  <= '0;
      lock_vc_reg <= '0;
    end else begin
      state_reg   <= state_next;
      rr_ptr_reg  <= rr_ptr_next;
      lock_vc_reg <= lock_vc_next;
    end
  end

  // Payload registers only move on a transfer so they hold through bubbles.
  always_ff @(posedge clk) begin
    if (flush) begin
      o_valid_reg <= 1'b0;
      o_flit_reg  <= '0;
      o_tail_reg  <= 1'b0;
      o_vc_reg    <= '0;
    end else if (load_en) begin
      o_valid_reg <= transfer;
      if (transfer) begin
        o_flit_reg <= xfer_flit;
        o_tail_reg <= xfer_tail;
        o_vc_reg   <= xfer_vec;
      end
    end
  end

  assign o_valid = o_valid_reg;
  assign o_flit  = o_flit_reg;
  assign o_tail  = o_tail_reg;
  assign o_vc    = o_vc_reg;

endmodule

// File: doc/tnoc_vc_output_mux.md
TNOC_VC_OUTPUT_MUX -- requirements
Module: tnoc_vc_output_mux

Interface
REQ-001 Parameter CHANNELS, default 2: number of virtual channels; legal range 1..8.
REQ-002 Parameter FLIT_WIDTH, default 64: flit payload width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_clear  input  1  synchronous flush; same effect as rst on all state.
REQ-006 i_valid  input  CHANNELS  per-VC flit valid from the per-VC source FIFOs.
REQ-007 o_ready  output  CHANNELS  per-VC accept; a flit transfers on VC i when i_valid[i] && o_ready[i].
REQ-008 i_flit  input  CHANNELS x FLIT_WIDTH  per-VC flit payload.
REQ-009 i_tail  input  CHANNELS  per-VC tail marker; 1 = last flit of a packet.
REQ-010 i_vc_almost_full  input  CHANNELS  per-VC almost-full from the downstream input FIFO.
REQ-011 o_valid  output  1  link flit valid.
REQ-012 i_ready  input  1  link accept from downstream, already selected by o_vc.
REQ-013 o_flit  output  FLIT_WIDTH  link flit payload.
REQ-014 o_tail  output  1  link tail marker.
REQ-015 o_vc  output  CHANNELS  one-hot VC tag of o_flit.

Function
REQ-016 Output stage: o_valid, o_flit, o_tail and o_vc are registers, with load_en = !o_valid || i_ready.
REQ-017 On a transfer from VC i: o_flit <= i_flit[i], o_tail <= i_tail[i], o_vc <= one-hot(i), and o_valid <= 1 on the next cycle.
REQ-018 When load_en = 1 and no upstream transfer occurs: o_valid <= 0; o_flit, o_tail and o_vc hold.
REQ-019 When o_valid = 1 and i_ready = 0: all output registers hold stable, and o_ready is all zero.
REQ-020 Latency is exactly 1 cycle from upstream transfer to o_valid; sustained throughput is 1 flit per cycle when i_ready is held at 1.
REQ-021 FSM has two states: IDLE (no packet owns the link) and BUSY (the link is locked to VC lock_vc).
REQ-022 IDLE arbitration: request[i] = i_valid[i] && !i_vc_almost_full[i].
REQ-023 IDLE grant: combinational round-robin starting at pointer rr_ptr; at most one grant per cycle.
REQ-024 IDLE o_ready: o_ready = grant when load_en = 1, otherwise all zero.
REQ-025 IDLE, granted head transfers with i_tail = 0: next state is BUSY and lock_vc <= granted index.
REQ-026 IDLE, granted head transfers with i_tail = 1 (single-flit packet): state stays IDLE.
REQ-027 rr_ptr <= (granted index + 1) mod CHANNELS on every head transfer; wraps from CHANNELS-1 to 0.
REQ-028 BUSY: o_ready[lock_vc] = load_en; every other o_ready bit is 0.
REQ-029 BUSY: i_vc_almost_full is ignored, so packets are never split.
REQ-030 BUSY: a transfer with i_tail = 1 returns the FSM to IDLE on the next cycle.
REQ-031 BUSY with i_valid[lock_vc] = 0: a bubble is inserted (o_valid falls if load_en), and the FSM stays BUSY.
REQ-032 Flits of different VCs are never interleaved within a packet; flit order within a VC is preserved.
REQ-033 No flit is dropped or duplicated: every upstream transfer yields exactly one link flit accepted by o_valid && i_ready.

Reset
REQ-034 On rst = 1 or i_clear = 1 at a clock edge: o_valid = 0, o_flit = 0, o_tail = 0, o_vc = 0, state = IDLE, rr_ptr = 0, lock_vc = 0.
REQ-035 While rst = 1 or i_clear = 1: o_ready is all zero.
REQ-036 rst or i_clear asserted mid-packet discards the held flit and the lock; the first cycle after deassertion arbitrates from rr_ptr = 0.
REQ-037 rst takes priority over all other inputs; i_clear has identical behaviour.

Verification
REQ-038 Reset check (CHANNELS=2): rst high 3 cycles with all i_valid = 1 -> o_ready = 00 and o_valid = 0 throughout; first cycle after release VC0 is granted, and the next cycle o_valid = 1 with o_vc = 01.
REQ-039 Round-robin: both VCs send continuous single-flit packets with i_ready = 1 -> o_vc sequence 01,10,01,10; rr_ptr wraps correctly.
REQ-040 Packet lock: VC0 4-flit packet and VC1 1-flit packet both pending -> VC0 flits 0..3 appear contiguously, then the VC1 flit; VC1 o_ready stays 0 throughout VC0 BUSY.
REQ-041 Backpressure: i_ready = 0 for 5 cycles mid-packet -> o_flit, o_tail and o_vc stable, o_ready = 00; after i_ready rises, the remaining flits arrive in order with none lost.
REQ-042 Almost-full: i_vc_almost_full = 01 with both VCs valid -> VC1 is granted; almost_full asserted mid-packet on the locked VC -> the packet still completes.
REQ-043 Clear mid-packet: i_clear pulsed on VC1 flit 2 of 4 -> next cycle o_valid = 0 and state = IDLE; a subsequent request is served starting at VC0 priority.
